// File: rtl/bus_demux3.sv
// One-entry 1-to-3 bus demultiplexer with valid/ready handshakes, illegal-select
// error pulse and saturating per-destination transfer counters.
module bus_demux3 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic              sel_err,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          sel_q, sel_d;
    logic                sel_err_q, sel_err_d;
    logic [CNT_W-1:0]    cnt_q [3];
    logic [CNT_W-1:0]    cnt_d [3];

    logic [2:0]          sel_oh;
    logic                up_hs;
    logic [2:0]          dn_hs;

    always_comb begin
        sel_oh = 3'b000;
        case (sel_q)
            2'd0:    sel_oh = 3'b001;
            2'd1:    sel_oh = 3'b010;
            2'd2:    sel_oh = 3'b100;
            default: sel_oh = 3'b000;
        endcase
        out_valid = (state_q == StHold) ? sel_oh : 3'b000;
        // In HOLD, ready passes straight through from the selected destination.
        in_ready  = !reset && ((state_q == StIdle) || (|(sel_oh & out_ready)));
        up_hs     = in_valid && in_ready;
        dn_hs     = out_valid & out_ready;
        out_data0 = out_valid[0] ? data_q : '0;
        out_data1 = out_valid[1] ? data_q : '0;
        out_data2 = out_valid[2] ? data_q : '0;
        sel_err   = sel_err_q;
        cnt0      = cnt_q[0];
        cnt1      = cnt_q[1];
        cnt2      = cnt_q[2];
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        sel_err_d = 1'b0;
        cnt_d     = cnt_q;

        for (int i = 0; i < 3; i++) begin
            if (dn_hs[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (up_hs) begin
                    if (in_sel == 2'b11) begin
                        sel_err_d = 1'b1;
                    end else begin
                        data_d  = in_data;
                        sel_d   = in_sel;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (|dn_hs) begin
                    if (up_hs && (in_sel != 2'b11)) begin
                        data_d = in_data;
                        sel_d  = in_sel;
                    end else begin
                        state_d   = StIdle;
                        sel_err_d = up_hs;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            data_q    <= '0;
            sel_q     <= 2'b00;
            sel_err_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_demux3.sv
// Self-checking bench for bus_demux3: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the held payload and counters.
module tb_bus_demux3;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data0, out_data1, out_data2;
    logic              sel_err;
    logic [CNT_W-1:0]  cnt0, cnt1, cnt2;

    bus_demux3 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .sel_err   (sel_err),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: a queue holding at most one pending payload.
    typedef struct {
        int          dest;
        logic [31:0] data;
    } pl_t;
    pl_t  held[$];
    int   m_cnt[3];
    bit   m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        m_err = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all();
        logic [2:0]  ev;
        logic [31:0] ed [3];
        logic        er;
        ev = 3'b000;
        for (int i = 0; i < 3; i++) ed[i] = 32'h0;
        if (held.size() != 0) begin
            ev[held[0].dest] = 1'b1;
            ed[held[0].dest] = held[0].data;
        end
        er = (held.size() == 0) || out_ready[held.size() != 0 ? held[0].dest : 0];
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_data0", out_data0, ed[0]);
        chk("out_data1", out_data1, ed[1]);
        chk("out_data2", out_data2, ed[2]);
        chk("sel_err", 32'(sel_err), 32'(m_err));
        chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        chk("cnt2", 32'(cnt2), 32'(m_cnt[2]));
    endtask

    task automatic model_step(input bit v, input int sel, input logic [31:0] d,
                              input logic [2:0] ordy);
        bit up, dn;
        int cmax;
        cmax = (1 << CNT_W) - 1;
        dn = (held.size() != 0) && ordy[held[0].dest];
        up = v && ((held.size() == 0) || dn);
        if (dn) begin
            if (m_cnt[held[0].dest] < cmax) m_cnt[held[0].dest]++;
            void'(held.pop_front());
        end
        m_err = up && (sel == 3);
        if (up && sel != 3) held.push_back('{dest: sel, data: d});
    endtask

    // One clock cycle: drive, check on the falling edge, advance the model on the rising edge.
    task automatic cycle(input bit v, input int sel, input logic [31:0] d,
                         input logic [2:0] ordy);
        in_valid  = v;
        in_sel    = 2'(sel);
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step(v, sel, d, ordy);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        out_ready = 3'b000;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_cnt0", 32'(cnt0), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single transfer to out 1
        cycle(1, 1, 32'hDEADBEEF, 3'b010);
        chk("single_valid", 32'(out_valid), 32'h2);
        chk("single_data1", out_data1, 32'hDEADBEEF);
        cycle(0, 0, 32'h0, 3'b010);
        chk("single_cnt1", 32'(cnt1), 32'h1);
        cycle(0, 0, 32'h0, 3'b000);

        // Back-pressure on out 2
        cycle(1, 2, 32'hCAFE0002, 3'b000);
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'h1111_0000 + 32'(i), 3'b011);
        cycle(0, 0, 32'h0, 3'b100);
        cycle(0, 0, 32'h0, 3'b000);
        chk("bp_cnt2", 32'(cnt2), 32'h1);

        // Streaming with no bubble
        for (int i = 0; i < 4; i++) cycle(1, (i == 3) ? 0 : i, 32'(i + 1), 3'b111);
        cycle(0, 0, 32'h0, 3'b111);
        cycle(0, 0, 32'h0, 3'b000);
        chk("stream_cnt0", 32'(cnt0), 32'h2);

        // Illegal select in IDLE, then in HOLD alongside a completing transfer
        cycle(1, 3, 32'h5, 3'b000);
        chk("ill_idle_err", 32'(sel_err), 32'h1);
        cycle(1, 0, 32'hA0, 3'b000);
        cycle(1, 3, 32'h5, 3'b001);
        chk("ill_hold_err", 32'(sel_err), 32'h1);
        chk("ill_hold_valid", 32'(out_valid), 32'h0);
        cycle(0, 0, 32'h0, 3'b000);

        // Saturation of cnt0
        for (int i = 0; i < 17; i++) cycle(1, 0, $urandom, 3'b001);
        cycle(0, 0, 32'h0, 3'b001);
        chk("sat_cnt0", 32'(cnt0), 32'hF);

        // Reset asserted mid-HOLD clears outputs before the next edge
        cycle(1, 1, 32'h77, 3'b000);
        chk("pre_rst_valid", 32'(out_valid), 32'h2);
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'h0);
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_data1", out_data1, 32'h0);
        chk("arst_cnt0", 32'(cnt0), 32'h0);
        chk("arst_cnt1", 32'(cnt1), 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(0, 0, 32'h0, 3'b111);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), $urandom,
                  3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
